cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_sequencer.sv | 135 +++++++++++++
 tb/tb_cpu_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// Multi-cycle accumulator sequencer: fetches 16-bit instructions, drives an external ALU,
// and presents OUT values over a valid/ready handshake.
module cpu_sequencer #(
  parameter int unsigned         ADDR_W   = 8,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              instr_req,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic              instr_ack,
  input  logic [15:0]       instr_data,
  output logic [3:0]        alu_code,
  output logic [15:0]       alu_a,
  output logic [15:0]       alu_b,
  input  logic [15:0]       alu_result,
  output logic              out_valid,
  output logic [15:0]       out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              halted
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StOutw,
    StHalt
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       acc_q, acc_d;
  logic [15:0]       ir_q, ir_d;

  logic [3:0]        opcode;
  logic [15:0]       imm_ext;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pc_inc;
  logic              is_alu_op;

  assign opcode    = ir_q[15:12];
  assign imm_ext   = {4'b0000, ir_q[11:0]};
  // Jump/branch targets take only the low ADDR_W bits of the immediate.
  assign target    = ADDR_W'(ir_q[11:0]);
  assign pc_inc    = pc_q + ADDR_W'(1);
  assign is_alu_op = (opcode <= 4'd6);

  assign instr_addr = pc_q;
  assign alu_a      = acc_q;
  assign alu_b      = imm_ext;
  assign busy       = (state_q != StIdle) && (state_q != StHalt);
  assign halted     = (state_q == StHalt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      acc_q   <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    acc_d     = acc_q;
    ir_d      = ir_q;
    instr_req = 1'b0;
    alu_code  = 4'b0000;
    out_valid = 1'b0;
    out_data  = '0;

    case (state_q)
      StIdle: begin
        if (start) state_d = StFetch;
      end

      StFetch: begin
        instr_req = 1'b1;
        if (instr_ack) begin
          ir_d    = instr_data;
          state_d = StDecode;
        end
      end

      StDecode: begin
        if (is_alu_op) alu_code = opcode;
        if (opcode == 4'hA)      state_d = StOutw;
        else if (opcode == 4'hF) state_d = StHalt;
        else                     state_d = StExec;
      end

      StExec: begin
        // ir is stable here, so re-deriving alu_code holds the DECODE value.
        if (is_alu_op) alu_code = opcode;
        state_d = StFetch;
        case (opcode)
          4'h7: pc_d = acc_q[15] ? target : pc_inc;
          4'h8: begin
            acc_d = imm_ext;
            pc_d  = pc_inc;
          end
          4'h9: pc_d = target;
          default: begin
            if (is_alu_op) acc_d = alu_result;
            pc_d = pc_inc;
          end
        endcase
      end

      StOutw: begin
        out_valid = 1'b1;
        out_data  = acc_q;
        if (out_ready) begin
          pc_d    = pc_inc;
          state_d = StFetch;
        end
      end

      StHalt: ;

      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: table of short programs checked at HALT, plus
// hand-written sequences for fetch stalls, OUT back-pressure, pc wrap and mid-flight reset.
module tb_cpu_sequencer;

  localparam int unsigned ADDR_W = 8;
  localparam logic [ADDR_W-1:0] RST_PC = 8'h00;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              instr_req;
  logic [ADDR_W-1:0] instr_addr;
  logic              instr_ack;
  logic [15:0]       instr_data;
  logic [3:0]        alu_code;
  logic [15:0]       alu_a, alu_b, alu_result;
  logic              out_valid;
  logic [15:0]       out_data;
  logic              out_ready = 1'b1;
  logic              busy, halted;

  logic              ack_gate = 1'b1;
  logic [15:0]       mem [256];

  int checks = 0;
  int errors = 0;

  cpu_sequencer #(.ADDR_W(ADDR_W), .RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .instr_req  (instr_req),
    .instr_addr (instr_addr),
    .instr_ack  (instr_ack),
    .instr_data (instr_data),
    .alu_code   (alu_code),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .busy       (busy),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  // Ack is not gated by instr_req, so it is also high outside FETCH.
  assign instr_ack  = ack_gate;
  assign instr_data = mem[instr_addr];

  always_comb begin
    case (alu_code)
      4'h0:    alu_result = alu_b;
      4'h1:    alu_result = ~alu_a;
      4'h2:    alu_result = alu_a & alu_b;
      4'h3:    alu_result = alu_a | alu_b;
      4'h4:    alu_result = alu_a + alu_b;
      4'h5:    alu_result = alu_a - alu_b;
      4'h6:    alu_result = alu_a ^ alu_b;
      default: alu_result = 16'h0000;
    endcase
  end

  typedef struct {
    logic [15:0] i0, i1, i2;
    logic [15:0] exp_acc;
    logic [7:0]  exp_pc;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  task automatic clear_mem();
    for (int a = 0; a < 256; a++) mem[a] = 16'hF000;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic run_to_halt(input string name, output int n);
    n = 0;
    while (!halted && n < 200) begin
      cyc();
      n++;
    end
    if (!halted) check({name, "_halt_timeout"}, 32'(halted), 32'd1);
  endtask

  task automatic wait_out_valid(input string name);
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      cyc();
      n++;
    end
    if (!out_valid) check({name, "_outvalid_timeout"}, 32'(out_valid), 32'd1);
  endtask

  vec_t vecs[$];

  initial begin
    int n;
    int outs;
    logic [15:0] seen;

    vecs.push_back('{16'h8005, 16'h4003, 16'hB000, 16'h0008, 8'h03});
    vecs.push_back('{16'h8800, 16'h1000, 16'hB000, 16'hF7FF, 8'h03});
    vecs.push_back('{16'h8800, 16'h1000, 16'h7010, 16'hF7FF, 8'h10});
    vecs.push_back('{16'h8001, 16'h7010, 16'hB000, 16'h0001, 8'h03});
    vecs.push_back('{16'h80F0, 16'h203C, 16'hB000, 16'h0030, 8'h03});
    vecs.push_back('{16'h80F0, 16'h300F, 16'hB000, 16'h00FF, 8'h03});
    vecs.push_back('{16'h8003, 16'h5005, 16'hB000, 16'hFFFE, 8'h03});
    vecs.push_back('{16'h8FFF, 16'h60F0, 16'hB000, 16'h0F0F, 8'h03});
    vecs.push_back('{16'h8123, 16'h0456, 16'hB000, 16'h0456, 8'h03});
    vecs.push_back('{16'h800A, 16'h9020, 16'hB000, 16'h000A, 8'h20});
    vecs.push_back('{16'h800A, 16'hE123, 16'hC000, 16'h000A, 8'h03});
    vecs.push_back('{16'h80AB, 16'h80CD, 16'hB000, 16'h00CD, 8'h03});
    vecs.push_back('{16'h8000, 16'h1000, 16'h4002, 16'h0001, 8'h03});
    vecs.push_back('{16'h8001, 16'h93FE, 16'hB000, 16'h0001, 8'hFE});

    // Reset state
    rst = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_req", 32'(instr_req), 32'd0);
    check("rst_pc", 32'(instr_addr), 32'(RST_PC));
    check("rst_acc", 32'(alu_a), 32'd0);
    cyc();
    rst = 1'b0;
    cyc();

    // Table: three-instruction programs, acc and pc observed once halted
    foreach (vecs[v]) begin
      clear_mem();
      mem[0] = vecs[v].i0;
      mem[1] = vecs[v].i1;
      mem[2] = vecs[v].i2;
      do_reset();
      pulse_start();
      run_to_halt($sformatf("vec%0d", v), n);
      check($sformatf("vec%0d_acc", v), 32'(alu_a), 32'(vecs[v].exp_acc));
      check($sformatf("vec%0d_pc", v), 32'(instr_addr), 32'(vecs[v].exp_pc));
      check($sformatf("vec%0d_busy", v), 32'(busy), 32'd0);
    end

    // LOADI 5; ADD 3; OUT; HALT with minimum latency
    clear_mem();
    mem[0] = 16'h8005;
    mem[1] = 16'h4003;
    mem[2] = 16'hA000;
    do_reset();
    out_ready = 1'b1;
    pulse_start();
    n = 0;
    outs = 0;
    seen = 16'h0000;
    while (!halted && n < 50) begin
      if (out_valid && out_ready) begin
        outs++;
        seen = out_data;
      end
      cyc();
      n++;
    end
    check("prog_out_data", 32'(seen), 32'h0008);
    check("prog_out_count", 32'(outs), 32'd1);
    check("prog_cycles", 32'(n), 32'd11);
    check("prog_halted", 32'(halted), 32'd1);
    check("prog_pc", 32'(instr_addr), 32'd3);
    start = 1'b1;
    cyc();
    cyc();
    start = 1'b0;
    check("halt_ignores_start", 32'(halted), 32'd1);
    check("halt_no_fetch", 32'(instr_req), 32'd0);
    check("halt_pc_hold", 32'(instr_addr), 32'd3);

    // Fetch stall: request and address held while ack is low
    clear_mem();
    mem[0] = 16'h4003;
    do_reset();
    ack_gate = 1'b0;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("stall%0d_req", i), 32'(instr_req), 32'd1);
      check($sformatf("stall%0d_addr", i), 32'(instr_addr), 32'd0);
      check($sformatf("stall%0d_ir", i), 32'(alu_b), 32'd0);
      cyc();
    end
    ack_gate = 1'b1;
    cyc();
    check("stall_decode_req", 32'(instr_req), 32'd0);
    check("stall_decode_ir", 32'(alu_b), 32'h0003);
    check("decode_alu_code", 32'(alu_code), 32'd4);
    cyc();
    check("exec_alu_code", 32'(alu_code), 32'd4);
    cyc();
    check("fetch_alu_code", 32'(alu_code), 32'd0);
    check("add_acc", 32'(alu_a), 32'h0003);
    check("add_pc", 32'(instr_addr), 32'd1);

    // OUT back-pressure
    clear_mem();
    mem[0] = 16'h807A;
    mem[1] = 16'hA000;
    do_reset();
    out_ready = 1'b0;
    pulse_start();
    wait_out_valid("bp");
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("bp%0d_data", i), 32'(out_data), 32'h007A);
      check($sformatf("bp%0d_pc", i), 32'(instr_addr), 32'd1);
      cyc();
    end
    out_ready = 1'b1;
    cyc();
    check("bp_accept_valid", 32'(out_valid), 32'd0);
    check("bp_accept_pc", 32'(instr_addr), 32'd2);

    // pc wrap: NOP at 0xFF goes to 0x00
    clear_mem();
    mem[0]    = 16'h90FF;
    mem[8'hFF] = 16'hB000;
    do_reset();
    pulse_start();
    n = 0;
    while (!(instr_req && instr_addr == 8'hFF) && n < 20) begin
      cyc();
      n++;
    end
    check("wrap_reach_ff", 32'(instr_addr), 32'hFF);
    cyc();
    cyc();
    cyc();
    check("wrap_req", 32'(instr_req), 32'd1);
    check("wrap_addr", 32'(instr_addr), 32'd0);

    // Reset during FETCH
    clear_mem();
    mem[0] = 16'h8001;
    do_reset();
    ack_gate = 1'b0;
    pulse_start();
    check("midfetch_req_before", 32'(instr_req), 32'd1);
    rst = 1'b1;
    #1;
    check("midfetch_req", 32'(instr_req), 32'd0);
    check("midfetch_busy", 32'(busy), 32'd0);
    cyc();
    rst = 1'b0;
    ack_gate = 1'b1;

    // Reset during OUTW, then no fetch until start
    clear_mem();
    mem[0] = 16'h807A;
    mem[1] = 16'hA000;
    do_reset();
    out_ready = 1'b0;
    pulse_start();
    wait_out_valid("midout");
    rst = 1'b1;
    #1;
    check("midout_valid", 32'(out_valid), 32'd0);
    check("midout_data", 32'(out_data), 32'd0);
    check("midout_acc", 32'(alu_a), 32'd0);
    check("midout_ir", 32'(alu_b), 32'd0);
    check("midout_busy", 32'(busy), 32'd0);
    check("midout_pc", 32'(instr_addr), 32'(RST_PC));
    cyc();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check($sformatf("idle%0d_req", i), 32'(instr_req), 32'd0);
    end
    pulse_start();
    check("restart_req", 32'(instr_req), 32'd1);
    check("restart_addr", 32'(instr_addr), 32'(RST_PC));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
